oled_spi_rx: RTL
================

# oled_spi_rx

SPI display receiver that decodes the command/pixel byte stream a host sends to an SSD1331/SSD1351-class OLED. It samples `spi_csn`/`spi_clk`/`spi_mosi`/`spi_dc`/`spi_resn` in the system clock domain and rebuilds bytes. It tracks the column/row address window and emits one pixel write (x, y, color) per received pixel. It sits behind the camera/OLED path as a display emulator, feeding a framebuffer or a loopback checker.

## Interface
- `C_COLOR_BITS`, 16: 8 means one byte per pixel; 16 means two bytes per pixel, MSB byte first.
- `C_X_SIZE`, 128: screen width in pixels.
- `C_Y_SIZE`, 128: screen height in pixels.
- `C_X_BITS`, $clog2(C_X_SIZE): x width.
- `C_Y_BITS`, $clog2(C_Y_SIZE): y width.
- `clk`  in  1  system clock; must be at least 4× the SPI clock frequency.
- `reset`  in  1  asynchronous, active-high.
- `spi_csn`  in  1  chip select, active low, asynchronous to `clk`.
- `spi_clk`  in  1  SPI clock; data is sampled on its rising edge.
- `spi_mosi`  in  1  serial data, MSB first.
- `spi_dc`  in  1  0 = command or argument byte, 1 = pixel data byte.
- `spi_resn`  in  1  display reset, active low.
- `cmd_valid`  out  1  one-cycle pulse per dc=0 byte.
- `cmd_byte`  out  8  the dc=0 byte; valid with `cmd_valid`.
- `cmd_is_arg`  out  1  1 when the byte is an argument of a preceding opcode.
- `pixel_valid`  out  1  one-cycle pulse per completed pixel.
- `x`  out  C_X_BITS  pixel column; valid with `pixel_valid`.
- `y`  out  C_Y_BITS  pixel row; valid with `pixel_valid`.
- `color`  out  C_COLOR_BITS  pixel value; valid with `pixel_valid`.

## Operation
- **Input sync.** All five SPI inputs pass through 2-FF synchronizers. A rising edge of `spi_clk` is previous-synced 0 and current-synced 1.
- **Byte assembly.**
  - On each `spi_clk` rising edge while synced `spi_csn`=0, shift `spi_mosi` into an 8-bit register and increment a 3-bit bit counter.
  - `spi_dc` is captured together with the 8th bit.
  - When synced `spi_csn`=1, the bit counter clears and any partial bits are discarded.
- **Command parser states:**
  - OPCODE: a dc=0 byte is an opcode. The remaining-argument count is loaded from the argument table. If the count is nonzero, go to ARG.
  - ARG: each dc=0 byte decrements the count. Return to OPCODE when the count reaches 0.
  - A dc=1 byte in ARG is treated as pixel data; the pending argument count is kept.
- **Argument table:**
  - 0x15 (column window) and 0x75 (row window): 2 arguments each.
  - 0x81, 0x82, 0x83, 0x87, 0xA0, 0xA1, 0xA2, 0xA8, 0xAD, 0xB1, 0xB3, 0xBB, 0xBE: 1 argument each.
  - Every other opcode: 0 arguments.
- **Window registers.**
  - 0x15 arguments load `x_start` then `x_end`; 0x75 arguments load `y_start` then `y_end`.
  - Arguments are truncated to C_X_BITS / C_Y_BITS.
  - When the last window argument is accepted, set x ← `x_start` and y ← `y_start`.
- **Pixel assembly.**
  - In 16-bit mode, the first dc=1 byte is held as the high byte and the second completes the pixel. In 8-bit mode, every dc=1 byte is a pixel.
  - Any dc=0 byte clears the byte phase.
- **Address advance** after each pixel:
  - If x == `x_end`: x ← `x_start`. Then, if y == `y_end`, y ← `y_start`; otherwise y increments.
  - Otherwise x increments.
  - If start > end, the coordinate wraps at the all-ones value of its width and continues from 0 until it equals end.
- **Reset and `spi_resn`.**
  - Asynchronous `reset`, or synced `spi_resn`=0 (applied synchronously while low), clears the following:
    - parser state → OPCODE, with the argument count and byte phase cleared;
    - window → x 0..C_X_SIZE-1 and y 0..C_Y_SIZE-1;
    - x = y = 0.
  - Reset values of all outputs are 0.

## Timing
- The byte is complete on the clk cycle in which the 8th synced rising edge is detected.
- `cmd_valid`, or the internal byte strobe, is registered on the next cycle: 4 clk after the raw 8th `spi_clk` rising edge.
- `pixel_valid` asserts in the same cycle as that byte strobe would, for the byte completing the pixel.
- x, y and `color` are valid only while `pixel_valid`=1. The address advance becomes visible on the following pulse.
- Minimum spacing between output pulses is 8 SPI clocks. No backpressure: the consumer must accept every pulse.
- If `spi_csn` rises mid-byte, no pulse is produced, but the pixel byte phase is retained. Pixels may span CS frames.

## Structure
- Package `oled_spi_pkg` holds:
  - opcode constants (`OP_SET_COLUMN`=0x15, `OP_SET_ROW`=0x75);
  - the `arg_count(byte)` function;
  - the parser state enum.
- Sub-module `spi_byte_rx` performs sync, edge detection, shifting and dc capture. It outputs `byte_strobe`, `byte`, `byte_dc`, and clears its bit counter on CS high.

## Test plan
- **Basic command:** send 0xAF with dc=0 at SPI clk = clk/4 → exactly one `cmd_valid` with `cmd_byte`=0xAF, `cmd_is_arg`=0, 4 clk after the 8th edge.
- **Window and pixels:** send 0x15,0x10,0x11 then 0x75,0x20,0x21 (dc=0), then 5 pixels 0xF800,0x07E0,0x001F,0xFFFF,0x1234 → pixels at (16,32),(17,32),(16,33),(17,33),(16,32) with those colors.
- **Full-screen wrap:** default window, 128×128+1 pixels → last pixel at (0,0) after (127,127).
- **Argument parsing:** send 0xA0,0x72 → second pulse has `cmd_is_arg`=1. A following 0xAF has `cmd_is_arg`=0.
- **CS abort:** 5 bits, then `spi_csn` high, then a full byte 0x5C → one `cmd_valid` with `cmd_byte`=0x5C and no corrupted byte. A high-byte-only pixel, then CS toggle, then low byte → one pixel.
- **Resets:**
  - `spi_resn` low mid-pixel, then a 16-bit pixel → pixel at (0,0) with the correct color.
  - Async `reset` asserted between clock edges → all outputs 0 immediately.

Source files
------------

// File: rtl/oled_spi_rx_pkg.sv
// Shared opcode constants, argument table and parser state type for the OLED SPI receiver.
package oled_spi_pkg;

   localparam logic [7:0] OP_SET_COLUMN = 8'h15;
   localparam logic [7:0] OP_SET_ROW    = 8'h75;

   typedef enum logic {
      ST_OPCODE,
      ST_ARG
   } parser_state_t;

   // Number of argument bytes that follow each SSD1331/SSD1351 opcode.
   function automatic logic [1:0] arg_count(input logic [7:0] op);
      case (op)
         OP_SET_COLUMN, OP_SET_ROW: arg_count = 2'd2;
         8'h81, 8'h82, 8'h83, 8'h87, 8'hA0, 8'hA1, 8'hA2,
         8'hA8, 8'hAD, 8'hB1, 8'hB3, 8'hBB, 8'hBE: arg_count = 2'd1;
         default: arg_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/oled_spi_rx_byte_rx.sv
// Brings the raw SPI pins into the clk domain and assembles MSB-first bytes with their dc flag.
module spi_byte_rx (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_csn,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_dc,
   input  logic       spi_resn,
   output logic       byte_strobe,
   output logic [7:0] byte_data,
   output logic       byte_dc,
   output logic       resn_sync
);

   logic [1:0] csn_ff, sclk_ff, mosi_ff, dc_ff, resn_ff;
   logic       sclk_prev;
   logic [2:0] bit_cnt;
   logic       sclk_rise;

   assign sclk_rise = sclk_ff[1] & ~sclk_prev;
   assign resn_sync = resn_ff[1];

   // Chip select and display reset idle deasserted so nothing is decoded straight out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csn_ff    <= 2'b11;
         sclk_ff   <= 2'b00;
         mosi_ff   <= 2'b00;
         dc_ff     <= 2'b00;
         resn_ff   <= 2'b11;
         sclk_prev <= 1'b0;
      end else begin
         csn_ff    <= {csn_ff[0], spi_csn};
         sclk_ff   <= {sclk_ff[0], spi_clk};
         mosi_ff   <= {mosi_ff[0], spi_mosi};
         dc_ff     <= {dc_ff[0], spi_dc};
         resn_ff   <= {resn_ff[0], spi_resn};
         sclk_prev <= sclk_ff[1];
      end
   end

   // Stale bits left by an aborted frame are pushed out by the next eight shifts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt     <= 3'd0;
         byte_data   <= 8'h00;
         byte_dc     <= 1'b0;
         byte_strobe <= 1'b0;
      end else begin
         byte_strobe <= 1'b0;
         if (csn_ff[1]) begin
            bit_cnt <= 3'd0;
         end else if (sclk_rise) begin
            byte_data <= {byte_data[6:0], mosi_ff[1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_strobe <= 1'b1;
               byte_dc     <= dc_ff[1];
            end
         end
      end
   end

endmodule

// File: rtl/oled_spi_rx.sv
// OLED display emulator: decodes the host command/pixel stream and emits one (x, y, color) write per pixel.
module oled_spi_rx #(
   parameter int C_COLOR_BITS = 16,
   parameter int C_X_SIZE     = 128,
   parameter int C_Y_SIZE     = 128,
   parameter int C_X_BITS     = $clog2(C_X_SIZE),
   parameter int C_Y_BITS     = $clog2(C_Y_SIZE)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    spi_csn,
   input  logic                    spi_clk,
   input  logic                    spi_mosi,
   input  logic                    spi_dc,
   input  logic                    spi_resn,
   output logic                    cmd_valid,
   output logic [7:0]              cmd_byte,
   output logic                    cmd_is_arg,
   output logic                    pixel_valid,
   output logic [C_X_BITS-1:0]     x,
   output logic [C_Y_BITS-1:0]     y,
   output logic [C_COLOR_BITS-1:0] color
);
   import oled_spi_pkg::*;

   localparam logic [C_X_BITS-1:0] X_LAST = C_X_BITS'(C_X_SIZE - 1);
   localparam logic [C_Y_BITS-1:0] Y_LAST = C_Y_BITS'(C_Y_SIZE - 1);

   logic                byte_strobe, byte_dc, resn_sync;
   logic [7:0]          byte_data;
   parser_state_t       state;
   logic [1:0]          args_left;
   logic [7:0]          cur_op;
   logic                hi_phase;
   logic [7:0]          hi_byte;
   logic [C_X_BITS-1:0] x_start, x_end, x_cur;
   logic [C_Y_BITS-1:0] y_start, y_end, y_cur;
   logic [15:0]         pix_word;

   spi_byte_rx u_byte_rx (
      .clk         (clk),
      .reset       (reset),
      .spi_csn     (spi_csn),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_dc      (spi_dc),
      .spi_resn    (spi_resn),
      .byte_strobe (byte_strobe),
      .byte_data   (byte_data),
      .byte_dc     (byte_dc),
      .resn_sync   (resn_sync)
   );

   always_comb begin
      pix_word = (C_COLOR_BITS == 16) ? {hi_byte, byte_data} : {8'h00, byte_data};
   end

   // Parser, window registers and pixel addressing share one state machine; x_start/y_start
   // are already loaded by the time the final window argument resets the address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_OPCODE;
         args_left   <= 2'd0;
         cur_op      <= 8'h00;
         hi_phase    <= 1'b0;
         hi_byte     <= 8'h00;
         x_start     <= '0;
         x_end       <= X_LAST;
         y_start     <= '0;
         y_end       <= Y_LAST;
         x_cur       <= '0;
         y_cur       <= '0;
         cmd_valid   <= 1'b0;
         cmd_byte    <= 8'h00;
         cmd_is_arg  <= 1'b0;
         pixel_valid <= 1'b0;
         x           <= '0;
         y           <= '0;
         color       <= '0;
      end else begin
         cmd_valid   <= 1'b0;
         pixel_valid <= 1'b0;
         if (!resn_sync) begin
            state     <= ST_OPCODE;
            args_left <= 2'd0;
            hi_phase  <= 1'b0;
            x_start   <= '0;
            x_end     <= X_LAST;
            y_start   <= '0;
            y_end     <= Y_LAST;
            x_cur     <= '0;
            y_cur     <= '0;
         end else if (byte_strobe && !byte_dc) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= byte_data;
            hi_phase  <= 1'b0;
            if (state == ST_OPCODE) begin
               cmd_is_arg <= 1'b0;
               cur_op     <= byte_data;
               args_left  <= arg_count(byte_data);
               if (arg_count(byte_data) != 2'd0) state <= ST_ARG;
            end else begin
               cmd_is_arg <= 1'b1;
               args_left  <= args_left - 2'd1;
               if (args_left == 2'd1) state <= ST_OPCODE;
               if (cur_op == OP_SET_COLUMN) begin
                  if (args_left == 2'd2) begin
                     x_start <= byte_data[C_X_BITS-1:0];
                  end else begin
                     x_end <= byte_data[C_X_BITS-1:0];
                     x_cur <= x_start;
                     y_cur <= y_start;
                  end
               end else if (cur_op == OP_SET_ROW) begin
                  if (args_left == 2'd2) begin
                     y_start <= byte_data[C_Y_BITS-1:0];
                  end else begin
                     y_end <= byte_data[C_Y_BITS-1:0];
                     x_cur <= x_start;
                     y_cur <= y_start;
                  end
               end
            end
         end else if (byte_strobe) begin
            if (C_COLOR_BITS == 16 && !hi_phase) begin
               hi_byte  <= byte_data;
               hi_phase <= 1'b1;
            end else begin
               hi_phase    <= 1'b0;
               pixel_valid <= 1'b1;
               x           <= x_cur;
               y           <= y_cur;
               color       <= pix_word[C_COLOR_BITS-1:0];
               if (x_cur == x_end) begin
                  x_cur <= x_start;
                  y_cur <= (y_cur == y_end) ? y_start : y_cur + 1'b1;
               end else begin
                  x_cur <= x_cur + 1'b1;
               end
            end
         end
      end
   end

endmodule
